branch_predictor: RTL and testbench

- Producer side of the fetch stage's prediction interface. Supplies `predict_pc_o`, the next fetch PC, from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Carries each prediction alongside its instruction into Decode and compares it there with the resolved next PC. On mismatch it raises `predict_miss_o` so fetch selects the corrected PC.
- Trains the BTB from Decode-stage resolution.

---
 rtl/branch_predictor.sv | 121 ++++++++++++
 tb/tb_branch_predictor.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Predicts the next fetch PC, checks the prediction when the instruction
// reaches Decode, and trains the table from Decode-stage resolution.
module branch_predictor #(
    parameter  int ENTRIES    = 64,
    localparam int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic [31:0] pc_f_i,
    output logic [31:0] predict_pc_o,
    output logic        predict_miss_o,
    input  logic [31:0] pc_plus_4_d_i,
    input  logic        branch_d_i,
    input  logic        taken_d_i,
    input  logic [31:0] pc_next_d_i,
    output logic [31:0] miss_count_o
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [31:0] predPc_q, predPc_d;
    logic        predV_q, predV_d;
    logic [31:0] missCount_q;

    logic [INDEX_BITS-1:0] fIndex, uIndex;
    logic [TAG_BITS-1:0]   fTag, uTag;
    logic                  fHit, uHit, doUpdate;
    logic [31:0]           pcD;
    logic                  unusedBits;

    // Fetch-side lookup: taken prediction only on a hit with a strong/weak-taken counter
    always_comb begin
        fIndex       = pc_f_i[INDEX_BITS+1:2];
        fTag         = pc_f_i[31:INDEX_BITS+2];
        fHit         = valid_q[fIndex] && (tag_q[fIndex] == fTag);
        predict_pc_o = (fHit && ctr_q[fIndex][1]) ? target_q[fIndex] : pc_f_i + 32'd4;
    end

    // Decode-side check and training decode: index and tag come from the Decode PC
    always_comb begin
        pcD            = pc_plus_4_d_i - 32'd4;
        uIndex         = pcD[INDEX_BITS+1:2];
        uTag           = pcD[31:INDEX_BITS+2];
        uHit           = valid_q[uIndex] && (tag_q[uIndex] == uTag);
        predict_miss_o = predV_q && !stall_d_i && (pc_next_d_i != predPc_q);
        doUpdate       = predV_q && !stall_d_i && branch_d_i;
    end

    // Next state of the prediction travelling with the instruction into Decode
    always_comb begin
        predPc_d = predPc_q;
        predV_d  = predV_q;
        if (!stall_d_i) begin
            if (flush_d_i) begin
                predPc_d = 32'd0;
                predV_d  = 1'b0;
            end else begin
                predPc_d = predict_pc_o;
                predV_d  = 1'b1;
            end
        end
    end

    // Decode shadow registers and the wrapping misprediction counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            predPc_q    <= 32'd0;
            predV_q     <= 1'b0;
            missCount_q <= 32'd0;
        end else begin
            predPc_q <= predPc_d;
            predV_q  <= predV_d;
            if (predict_miss_o) begin
                missCount_q <= missCount_q + 32'd1;
            end
        end
    end

    // BTB training: allocate on taken miss, saturate counters on hits
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (doUpdate) begin
            if (taken_d_i) begin
                if (uHit) begin
                    target_q[uIndex] <= pc_next_d_i;
                    if (ctr_q[uIndex] != 2'b11) begin
                        ctr_q[uIndex] <= ctr_q[uIndex] + 2'd1;
                    end
                end else begin
                    valid_q[uIndex]  <= 1'b1;
                    tag_q[uIndex]    <= uTag;
                    target_q[uIndex] <= pc_next_d_i;
                    ctr_q[uIndex]    <= 2'b10;
                end
            end else if (uHit && (ctr_q[uIndex] != 2'b00)) begin
                ctr_q[uIndex] <= ctr_q[uIndex] - 2'd1;
            end
        end
    end

    assign miss_count_o = missCount_q;

    // Fetch stall never touches this block; Decode PC low bits carry no index/tag
    assign unusedBits = ^{stall_f_i, pcD[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic, all compared against a behavioural model of the BTB rules.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_f_i, stall_d_i, flush_d_i;
    logic [31:0] pc_f_i;
    logic [31:0] predict_pc_o;
    logic        predict_miss_o;
    logic [31:0] pc_plus_4_d_i;
    logic        branch_d_i, taken_d_i;
    logic [31:0] pc_next_d_i;
    logic [31:0] miss_count_o;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_f_i      (stall_f_i),
        .stall_d_i      (stall_d_i),
        .flush_d_i      (flush_d_i),
        .pc_f_i         (pc_f_i),
        .predict_pc_o   (predict_pc_o),
        .predict_miss_o (predict_miss_o),
        .pc_plus_4_d_i  (pc_plus_4_d_i),
        .branch_d_i     (branch_d_i),
        .taken_d_i      (taken_d_i),
        .pc_next_d_i    (pc_next_d_i),
        .miss_count_o   (miss_count_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: each line remembers the full PC of the branch it holds
    bit          mValid  [ENTRIES];
    logic [31:0] mPc     [ENTRIES];
    logic [31:0] mTarget [ENTRIES];
    int          mCtr    [ENTRIES];
    bit          mPredV;
    logic [31:0] mPredPc;
    logic [31:0] mMissCount;

    typedef struct {
        logic [31:0] pcF;
        logic        stD;
        logic        fl;
        logic [31:0] pp4;
        logic        br;
        logic        tk;
        logic [31:0] pn;
        bit          cPc;
        logic [31:0] ePc;
        int          eMiss;
        int          eCnt;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pcF, input logic stD, input logic fl,
                                input logic [31:0] pp4, input logic br, input logic tk,
                                input logic [31:0] pn, input bit cPc, input logic [31:0] ePc,
                                input int eMiss, input int eCnt);
        vec_t v;
        v.pcF = pcF; v.stD = stD; v.fl = fl; v.pp4 = pp4; v.br = br; v.tk = tk;
        v.pn = pn; v.cPc = cPc; v.ePc = ePc; v.eMiss = eMiss; v.eCnt = eCnt;
        return v;
    endfunction

    function automatic int lineOf(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(ENTRIES));
    endfunction

    function automatic bit hitAt(input logic [31:0] pc);
        int idx;
        idx = lineOf(pc);
        return mValid[idx] && ((mPc[idx] / 32'(ENTRIES * 4)) == (pc / 32'(ENTRIES * 4)));
    endfunction

    function automatic logic [31:0] expPredict(input logic [31:0] pc);
        if (hitAt(pc) && mCtr[lineOf(pc)] >= 2) return mTarget[lineOf(pc)];
        return pc + 32'd4;
    endfunction

    function automatic logic expMiss();
        return mPredV && !stall_d_i && (pc_next_d_i != mPredPc);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0; mPc[i] = 32'd0; mTarget[i] = 32'd0; mCtr[i] = 1;
        end
        mPredV = 1'b0; mPredPc = 32'd0; mMissCount = 32'd0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT
    task automatic modelEdge();
        logic [31:0] predNow, pcd;
        int idx;
        predNow = expPredict(pc_f_i);
        if (expMiss()) mMissCount = mMissCount + 32'd1;
        if (mPredV && !stall_d_i && branch_d_i) begin
            pcd = pc_plus_4_d_i - 32'd4;
            idx = lineOf(pcd);
            if (taken_d_i) begin
                if (hitAt(pcd)) begin
                    mTarget[idx] = pc_next_d_i;
                    mCtr[idx]    = (mCtr[idx] < 3) ? mCtr[idx] + 1 : 3;
                end else begin
                    mValid[idx] = 1'b1; mPc[idx] = pcd; mTarget[idx] = pc_next_d_i; mCtr[idx] = 2;
                end
            end else if (hitAt(pcd)) begin
                mCtr[idx] = (mCtr[idx] > 0) ? mCtr[idx] - 1 : 0;
            end
        end
        if (!stall_d_i) begin
            if (flush_d_i) begin mPredV = 1'b0; mPredPc = 32'd0; end
            else begin mPredV = 1'b1; mPredPc = predNow; end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic applyVec(input vec_t v);
        pc_f_i = v.pcF; stall_f_i = v.stD; stall_d_i = v.stD; flush_d_i = v.fl;
        pc_plus_4_d_i = v.pp4; branch_d_i = v.br; taken_d_i = v.tk; pc_next_d_i = v.pn;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        pc_f_i = 32'h00400000;
        #1;
        vectors++;
        if (predict_pc_o !== 32'h00400004) begin
            miscompares++; $display("[TB] FAIL reset_predict got %h expected %h", predict_pc_o, 32'h00400004);
        end
        vectors++;
        if (predict_miss_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_miss got %b expected 0", predict_miss_o);
        end
        vectors++;
        if (miss_count_o !== 32'd0) begin
            miscompares++; $display("[TB] FAIL reset_count got %0d expected 0", miss_count_o);
        end
        pc_f_i = 32'hFFFFFFFC;
        #1;
        vectors++;
        if (predict_pc_o !== 32'h00000000) begin
            miscompares++; $display("[TB] FAIL reset_wrap got %h expected 00000000", predict_pc_o);
        end
        modelReset();
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_taken_branch();
        vec_t seq[$];
        seq.push_back(mk(32'h00400010, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00400014, 0, 0));
        seq.push_back(mk(32'h00400014, 0, 0, 32'h00400014, 1, 1, 32'h00400040, 1, 32'h00400018, 1, 0));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400018, 0, 0, 32'h00400018, 1, 32'h00400040, 0, 1));
        seq.push_back(mk(32'h00400040, 0, 0, 32'h00400014, 1, 1, 32'h00400040, 1, 32'h00400044, 0, 1));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400044, 0, 0, 32'h00400044, 1, 32'h00400040, 0, 1));
        foreach (seq[i]) begin
            applyVec(seq[i]);
            vectors++;
            if (predict_pc_o !== expPredict(pc_f_i)) begin
                miscompares++; $display("[TB] FAIL taken_predict step %0d got %h expected %h", i, predict_pc_o, expPredict(pc_f_i));
            end
            vectors++;
            if (predict_miss_o !== expMiss()) begin
                miscompares++; $display("[TB] FAIL taken_miss step %0d got %b expected %b", i, predict_miss_o, expMiss());
            end
            vectors++;
            if (miss_count_o !== mMissCount) begin
                miscompares++; $display("[TB] FAIL taken_count step %0d got %0d expected %0d", i, miss_count_o, mMissCount);
            end
            if (seq[i].cPc) begin
                vectors++;
                if (predict_pc_o !== seq[i].ePc) begin
                    miscompares++; $display("[TB] FAIL taken_const_pc step %0d got %h expected %h", i, predict_pc_o, seq[i].ePc);
                end
            end
            vectors++;
            if (predict_miss_o !== seq[i].eMiss[0] || miss_count_o !== 32'(seq[i].eCnt)) begin
                miscompares++; $display("[TB] FAIL taken_const_miss step %0d got %b/%0d expected %0d/%0d",
                                        i, predict_miss_o, miss_count_o, seq[i].eMiss, seq[i].eCnt);
            end
            modelEdge();
        end
    endtask

    task automatic test_not_taken();
        vec_t seq[$];
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400014, 1, 1, 32'h00400040, 1, 32'h00400040, 0, 1));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400014, 1, 0, 32'h00400014, 1, 32'h00400040, 1, 1));
        seq.push_back(mk(32'h00400014, 0, 0, 32'h00400014, 1, 0, 32'h00400014, 1, 32'h00400018, 1, 2));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400018, 0, 0, 32'h00400018, 1, 32'h00400014, 0, 3));
        seq.push_back(mk(32'h00400014, 0, 0, 32'h00400014, 1, 0, 32'h00400014, 1, 32'h00400018, 0, 3));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400018, 0, 0, 32'h00400018, 1, 32'h00400014, 0, 3));
        seq.push_back(mk(32'h00400014, 0, 0, 32'h00400014, 1, 0, 32'h00400014, 1, 32'h00400018, 0, 3));
        foreach (seq[i]) begin
            applyVec(seq[i]);
            vectors++;
            if (predict_pc_o !== expPredict(pc_f_i)) begin
                miscompares++; $display("[TB] FAIL nt_predict step %0d got %h expected %h", i, predict_pc_o, expPredict(pc_f_i));
            end
            vectors++;
            if (predict_miss_o !== expMiss()) begin
                miscompares++; $display("[TB] FAIL nt_miss step %0d got %b expected %b", i, predict_miss_o, expMiss());
            end
            vectors++;
            if (predict_pc_o !== seq[i].ePc) begin
                miscompares++; $display("[TB] FAIL nt_const_pc step %0d got %h expected %h", i, predict_pc_o, seq[i].ePc);
            end
            vectors++;
            if (predict_miss_o !== seq[i].eMiss[0] || miss_count_o !== 32'(seq[i].eCnt)) begin
                miscompares++; $display("[TB] FAIL nt_const_miss step %0d got %b/%0d expected %0d/%0d",
                                        i, predict_miss_o, miss_count_o, seq[i].eMiss, seq[i].eCnt);
            end
            modelEdge();
        end
    endtask

    task automatic test_stall();
        vec_t seq[$];
        seq.push_back(mk(32'h00400020, 0, 0, 32'h00400018, 0, 0, 32'h00400018, 1, 32'h00400024, 0, 3));
        for (int k = 0; k < 3; k++)
            seq.push_back(mk(32'h00400020, 1, 0, 32'h00400024, 1, 1, 32'h00400080, 1, 32'h00400024, 0, 3));
        seq.push_back(mk(32'h00400020, 0, 0, 32'h00400024, 1, 1, 32'h00400080, 1, 32'h00400024, 1, 3));
        seq.push_back(mk(32'h00400080, 0, 0, 32'h00400024, 1, 1, 32'h00400080, 1, 32'h00400084, 1, 4));
        seq.push_back(mk(32'h00400020, 0, 0, 32'h00400084, 0, 0, 32'h00400084, 1, 32'h00400080, 0, 5));
        foreach (seq[i]) begin
            applyVec(seq[i]);
            vectors++;
            if (predict_pc_o !== expPredict(pc_f_i)) begin
                miscompares++; $display("[TB] FAIL stall_predict step %0d got %h expected %h", i, predict_pc_o, expPredict(pc_f_i));
            end
            vectors++;
            if (predict_miss_o !== expMiss()) begin
                miscompares++; $display("[TB] FAIL stall_miss step %0d got %b expected %b", i, predict_miss_o, expMiss());
            end
            vectors++;
            if (predict_pc_o !== seq[i].ePc) begin
                miscompares++; $display("[TB] FAIL stall_const_pc step %0d got %h expected %h", i, predict_pc_o, seq[i].ePc);
            end
            vectors++;
            if (predict_miss_o !== seq[i].eMiss[0] || miss_count_o !== 32'(seq[i].eCnt)) begin
                miscompares++; $display("[TB] FAIL stall_const_miss step %0d got %b/%0d expected %0d/%0d",
                                        i, predict_miss_o, miss_count_o, seq[i].eMiss, seq[i].eCnt);
            end
            modelEdge();
        end
    endtask

    task automatic test_flush();
        vec_t seq[$];
        seq.push_back(mk(32'h00400030, 0, 1, 32'h00400024, 1, 1, 32'h00400080, 1, 32'h00400034, 0, 5));
        seq.push_back(mk(32'h00400034, 0, 0, 32'h00400034, 1, 1, 32'h0040099C, 1, 32'h00400038, 0, 5));
        seq.push_back(mk(32'h00400034, 0, 0, 32'h00400038, 0, 0, 32'h00400038, 1, 32'h00400038, 0, 5));
        foreach (seq[i]) begin
            applyVec(seq[i]);
            vectors++;
            if (predict_pc_o !== expPredict(pc_f_i)) begin
                miscompares++; $display("[TB] FAIL flush_predict step %0d got %h expected %h", i, predict_pc_o, expPredict(pc_f_i));
            end
            vectors++;
            if (predict_miss_o !== expMiss()) begin
                miscompares++; $display("[TB] FAIL flush_miss step %0d got %b expected %b", i, predict_miss_o, expMiss());
            end
            vectors++;
            if (predict_pc_o !== seq[i].ePc) begin
                miscompares++; $display("[TB] FAIL flush_const_pc step %0d got %h expected %h", i, predict_pc_o, seq[i].ePc);
            end
            vectors++;
            if (predict_miss_o !== seq[i].eMiss[0] || miss_count_o !== 32'(seq[i].eCnt)) begin
                miscompares++; $display("[TB] FAIL flush_const_miss step %0d got %b/%0d expected %0d/%0d",
                                        i, predict_miss_o, miss_count_o, seq[i].eMiss, seq[i].eCnt);
            end
            modelEdge();
        end
    endtask

    task automatic test_alias();
        vec_t seq[$];
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400038, 0, 0, 32'h00400038, 1, 32'h00400014, 0, 5));
        seq.push_back(mk(32'h00400110, 0, 0, 32'h00400014, 1, 1, 32'h00400040, 1, 32'h00400114, 1, 5));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400014, 1, 1, 32'h00400040, 1, 32'h00400014, 1, 6));
        seq.push_back(mk(32'h00400110, 0, 0, 32'h00400014, 1, 1, 32'h00400040, 1, 32'h00400114, 1, 7));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400114, 0, 0, 32'h00400114, 1, 32'h00400040, 0, 8));
        seq.push_back(mk(32'h00400110, 0, 0, 32'h00400014, 1, 1, 32'h00400040, 1, 32'h00400114, 0, 8));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400114, 1, 1, 32'h00400200, 1, 32'h00400040, 1, 8));
        seq.push_back(mk(32'h00400110, 0, 0, 32'h00400014, 0, 0, 32'h00400014, 1, 32'h00400200, 1, 9));
        seq.push_back(mk(32'h00400010, 0, 0, 32'h00400114, 1, 1, 32'h00400200, 1, 32'h00400014, 0, 10));
        foreach (seq[i]) begin
            applyVec(seq[i]);
            vectors++;
            if (predict_pc_o !== expPredict(pc_f_i)) begin
                miscompares++; $display("[TB] FAIL alias_predict step %0d got %h expected %h", i, predict_pc_o, expPredict(pc_f_i));
            end
            vectors++;
            if (predict_miss_o !== expMiss()) begin
                miscompares++; $display("[TB] FAIL alias_miss step %0d got %b expected %b", i, predict_miss_o, expMiss());
            end
            vectors++;
            if (predict_pc_o !== seq[i].ePc) begin
                miscompares++; $display("[TB] FAIL alias_const_pc step %0d got %h expected %h", i, predict_pc_o, seq[i].ePc);
            end
            vectors++;
            if (predict_miss_o !== seq[i].eMiss[0] || miss_count_o !== 32'(seq[i].eCnt)) begin
                miscompares++; $display("[TB] FAIL alias_const_miss step %0d got %b/%0d expected %0d/%0d",
                                        i, predict_miss_o, miss_count_o, seq[i].eMiss, seq[i].eCnt);
            end
            modelEdge();
        end
    endtask

    task automatic test_random();
        logic [31:0] lastFetch, pick;
        vec_t v;
        lastFetch = 32'h00400000;
        for (int n = 0; n < 400; n++) begin
            pick  = 32'h00400000 + 32'(4 * $urandom_range(0, 7)) + (($urandom % 2) ? 32'h100 : 32'h0);
            v.pcF = ($urandom % 32 == 0) ? 32'hFFFFFFFC : pick;
            v.stD = ($urandom % 8 == 0);
            v.fl  = ($urandom % 8 == 0);
            v.pp4 = (($urandom % 4 != 0) ? lastFetch
                    : 32'h00400000 + 32'(4 * $urandom_range(0, 15))) + 32'd4;
            v.br  = $urandom % 2;
            v.tk  = v.br ? 1'($urandom % 2) : 1'b0;
            v.pn  = v.tk ? 32'h00400400 + (((v.pp4 - 32'd4) >> 2) & 32'd3) * 32'd4 : v.pp4;
            v.cPc = 0; v.ePc = 32'd0; v.eMiss = -1; v.eCnt = -1;
            applyVec(v);
            if (!v.stD) lastFetch = v.pcF;
            vectors++;
            if (predict_pc_o !== expPredict(pc_f_i)) begin
                miscompares++; $display("[TB] FAIL rand_predict cycle %0d got %h expected %h", n, predict_pc_o, expPredict(pc_f_i));
            end
            vectors++;
            if (predict_miss_o !== expMiss()) begin
                miscompares++; $display("[TB] FAIL rand_miss cycle %0d got %b expected %b", n, predict_miss_o, expMiss());
            end
            vectors++;
            if (miss_count_o !== mMissCount) begin
                miscompares++; $display("[TB] FAIL rand_count cycle %0d got %0d expected %0d", n, miss_count_o, mMissCount);
            end
            modelEdge();
        end
    endtask

    task automatic test_midreset();
        pc_f_i = 32'h00400010; stall_f_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0;
        pc_plus_4_d_i = 32'h00400014; branch_d_i = 1'b1; taken_d_i = 1'b1; pc_next_d_i = 32'hDEAD0000;
        #1;
        rst_i = 1'b0;
        #1;
        vectors++;
        if (predict_pc_o !== 32'h00400014) begin
            miscompares++; $display("[TB] FAIL midreset_predict got %h expected 00400014", predict_pc_o);
        end
        vectors++;
        if (predict_miss_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_miss got %b expected 0", predict_miss_o);
        end
        vectors++;
        if (miss_count_o !== 32'd0) begin
            miscompares++; $display("[TB] FAIL midreset_count got %0d expected 0", miss_count_o);
        end
        modelReset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        vectors++;
        if (predict_miss_o !== 1'b0 || predict_pc_o !== 32'h00400014) begin
            miscompares++; $display("[TB] FAIL post_reset_first got %b/%h expected 0/00400014", predict_miss_o, predict_pc_o);
        end
        modelEdge();
        #1;
        vectors++;
        if (miss_count_o !== 32'd0 || predict_pc_o !== 32'h00400014) begin
            miscompares++; $display("[TB] FAIL post_reset_second got %0d/%h expected 0/00400014", miss_count_o, predict_pc_o);
        end
    endtask

    // Scenario sequence
    initial begin
        rst_i = 1'b0; stall_f_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0;
        pc_f_i = 32'd0; pc_plus_4_d_i = 32'd0; branch_d_i = 1'b0; taken_d_i = 1'b0; pc_next_d_i = 32'd0;
        test_reset();
        test_taken_branch();
        test_not_taken();
        test_stall();
        test_flush();
        test_alias();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
